// File: rtl/rf_access_sequencer.sv
// Multicycle controller that serialises the 4x8 register file's single address port:
// it reads rs then rd, runs one ALU op, and writes the result back to rd with a strobe.
module rf_access_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned WRITE_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rf_out,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              carry
);

    localparam int unsigned CNT_W = (WRITE_PULSE > 1) ? $clog2(WRITE_PULSE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRITE_PULSE - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_MOVI = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_d, busy_d, done_d, zero_d, carry_d;

    logic [DATA_W:0]   sum_c, diff_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              alu_carry_c;

    // ALU: operand A is the rd read data arriving on rf_out, operand B was captured from rs
    always_comb begin
        sum_c       = {1'b0, rf_out} + {1'b0, opb_q};
        diff_c      = {1'b0, rf_out} - {1'b0, opb_q};
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_c   = sum_c[DATA_W-1:0];
                alu_carry_c = sum_c[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_res_c   = diff_c[DATA_W-1:0];
                alu_carry_c = diff_c[DATA_W];
            end
            OP_AND:  alu_res_c = rf_out & opb_q;
            OP_OR:   alu_res_c = rf_out | opb_q;
            OP_NOT:  alu_res_c = ~opb_q;
            OP_MOV:  alu_res_c = opb_q;
            OP_MOVI: alu_res_c = imm_q;
            default: alu_res_c = '0;
        endcase
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        addr_d  = rf_address;
        wdata_d = rf_write_data;
        we_d    = 1'b0;
        done_d  = 1'b0;
        zero_d  = zero;
        carry_d = carry;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ_A;
                    op_d    = op;
                    rd_d    = rd;
                    imm_d   = imm;
                    addr_d  = rs;
                end
            end
            S_READ_A: begin
                opb_d   = rf_out;
                addr_d  = rd_q;
                state_d = S_READ_B;
            end
            S_READ_B: begin
                wdata_d = alu_res_c;
                zero_d  = (alu_res_c == '0);
                carry_d = alu_carry_c;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_CMP) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    we_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    we_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, latched request and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            opb_q         <= '0;
            cnt_q         <= '0;
            rf_address    <= '0;
            rf_write_data <= '0;
            rf_reg_write  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            zero          <= 1'b0;
            carry         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            opb_q         <= opb_d;
            cnt_q         <= cnt_d;
            rf_address    <= addr_d;
            rf_write_data <= wdata_d;
            rf_reg_write  <= we_d;
            busy          <= busy_d;
            done          <= done_d;
            zero          <= zero_d;
            carry         <= carry_d;
        end
    end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: two instances (strobe width 1 and 3), each in front of
// its own 4x8 register file, driven by directed and random ops against a reference model.
module tb_rf_access_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;

    logic [7:0] rf_out1, rf_out3, wd1, wd3;
    logic [1:0] addr1, addr3;
    logic       we1, we3, busy1, busy3, done1, done3, zero1, zero3, carry1, carry3;

    logic [7:0] rf1 [4];
    logic [7:0] rf3 [4];
    logic       pre_we, pre_sel;
    logic [1:0] pre_addr;
    logic [7:0] pre_data;

    logic [7:0] mir [2][4];
    bit         sel;
    logic       m_done, m_busy, m_we, m_zero, m_carry;
    logic [1:0] m_addr;
    logic [7:0] m_wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_access_sequencer #(.DATA_W(8), .ADDR_W(2), .WRITE_PULSE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .rd(rd), .rs(rs), .imm(imm),
        .rf_out(rf_out1), .rf_address(addr1), .rf_write_data(wd1), .rf_reg_write(we1),
        .busy(busy1), .done(done1), .zero(zero1), .carry(carry1)
    );

    rf_access_sequencer #(.DATA_W(8), .ADDR_W(2), .WRITE_PULSE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op(op), .rd(rd), .rs(rs), .imm(imm),
        .rf_out(rf_out3), .rf_address(addr3), .rf_write_data(wd3), .rf_reg_write(we3),
        .busy(busy3), .done(done3), .zero(zero3), .carry(carry3)
    );

    // Register files: combinational read, write on the clock edge while the strobe is high
    assign rf_out1 = rf1[addr1];
    assign rf_out3 = rf3[addr3];

    always @(posedge clk) begin
        if (pre_we && !pre_sel) rf1[pre_addr] <= pre_data;
        else if (we1)           rf1[addr1]    <= wd1;
        if (pre_we && pre_sel)  rf3[pre_addr] <= pre_data;
        else if (we3)           rf3[addr3]    <= wd3;
    end

    // View of the instance under test
    always_comb begin
        if (sel) begin
            m_done = done3; m_busy = busy3; m_we = we3; m_zero = zero3; m_carry = carry3;
            m_addr = addr3; m_wd = wd3;
        end else begin
            m_done = done1; m_busy = busy1; m_we = we1; m_zero = zero1; m_carry = carry1;
            m_addr = addr1; m_wd = wd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start3 = v;
        else   start1 = v;
    endtask

    function automatic logic [7:0] rf_val(input bit s, input int i);
        return s ? rf3[i] : rf1[i];
    endfunction

    // Reference: result, borrow/carry and whether the op writes back
    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] im, output logic [7:0] r, output logic c,
                         output bit wr);
        int s;
        c  = 1'b0;
        wr = (o != 3'd7);
        case (o)
            3'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); c = (s > 255); end
            3'd1, 3'd7: begin
                s = int'(a) - int'(b);
                r = 8'((s + 256) % 256);
                c = (s < 0);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~b;
            3'd5: r = b;
            default: r = im;
        endcase
    endtask

    task automatic preload(input bit s, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_sel = s; pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        mir[s][a] = d;
    endtask

    task automatic run_op(input bit s, input logic [2:0] o, input logic [1:0] d,
                          input logic [1:0] r, input logic [7:0] im, input bit inj);
        logic [7:0] res, hold_wd;
        logic [1:0] hold_addr;
        logic       c;
        bit         wr;
        int         wp, lat, hi, extra;
        wp = s ? 3 : 1;
        model(o, mir[s][d], mir[s][r], im, res, c, wr);
        sel = s;
        @(negedge clk);
        op = o; rd = d; rs = r; imm = im;
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        op = 3'($urandom); rd = 2'($urandom); rs = 2'($urandom); imm = 8'($urandom);
        check("busy_after_accept", 32'(m_busy), 32'd1);
        lat = 0; hi = 0; hold_wd = '0; hold_addr = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            set_start(s, (inj && cyc == 1) ? 1'b1 : 1'b0);
            if (m_we) begin
                hi++;
                if (hi == 1) begin
                    hold_wd = m_wd; hold_addr = m_addr;
                    check("wr_addr", 32'(m_addr), 32'(d));
                    check("wr_data", 32'(m_wd), 32'(res));
                end else begin
                    check("wr_data_stable", 32'(m_wd), 32'(hold_wd));
                    check("wr_addr_stable", 32'(m_addr), 32'(hold_addr));
                end
            end
            if (m_done) begin
                lat = cyc;
                break;
            end
        end
        check("done_latency", 32'(lat), wr ? 32'(3 + wp) : 32'd3);
        check("strobe_cycles", 32'(hi), wr ? 32'(wp) : 32'd0);
        check("zero_flag", 32'(m_zero), 32'(res == 8'h00));
        check("carry_flag", 32'(m_carry), 32'(c));
        if (wr) check("done_addr_held", 32'(m_addr), 32'(d));
        @(posedge clk);
        #1;
        check("done_one_cycle", {30'd0, m_done, m_busy}, 32'd0);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (m_done || m_busy) extra++;
        end
        check("no_extra_done", 32'(extra), 32'd0);
        check("flags_held", {30'd0, m_zero, m_carry}, {30'd0, res == 8'h00, c});
        if (wr) mir[s][d] = res;
        for (int i = 0; i < 4; i++) check("regfile", 32'(rf_val(s, i)), 32'(mir[s][i]));
    endtask

    initial begin
        int guard;
        rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
        op = '0; rd = '0; rs = '0; imm = '0;
        pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin mir[0][i] = '0; mir[1][i] = '0; end

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs1", {13'd0, addr1, wd1, we1, busy1, done1, zero1, carry1}, 32'd0);
        check("reset_outputs3", {13'd0, addr3, wd3, we3, busy3, done3, zero3, carry3}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            preload(1'b0, 2'(i), 8'($urandom));
            preload(1'b1, 2'(i), 8'($urandom));
        end

        // MOVI r2,0x5A
        run_op(1'b0, 3'd6, 2'd2, 2'd0, 8'h5A, 1'b0);
        // ADD r0,r1 with carry out
        preload(1'b0, 2'd0, 8'hF0);
        preload(1'b0, 2'd1, 8'h20);
        run_op(1'b0, 3'd0, 2'd0, 2'd1, 8'h00, 1'b0);
        // CMP r3,r1 with borrow, no write back
        preload(1'b0, 2'd3, 8'h05);
        preload(1'b0, 2'd1, 8'h07);
        run_op(1'b0, 3'd7, 2'd3, 2'd1, 8'h00, 1'b0);
        // SUB r1,r1 with a start pulse during busy
        preload(1'b0, 2'd1, 8'h33);
        run_op(1'b0, 3'd1, 2'd1, 2'd1, 8'h00, 1'b1);

        // Reset while the AND write strobe is high
        preload(1'b0, 2'd1, 8'h3C);
        preload(1'b0, 2'd2, 8'hF5);
        sel = 1'b0;
        @(negedge clk);
        op = 3'd2; rd = 2'd1; rs = 2'd2; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        guard = 0;
        while (!we1 && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("and_strobe_seen", 32'(we1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_outputs", {13'd0, addr1, wd1, we1, busy1, done1, zero1, carry1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_abandoned_write", 32'(rf1[1]), 32'h3C);
        run_op(1'b0, 3'd6, 2'd1, 2'd0, 8'h00, 1'b0);

        // OR r2,r0 with a three-cycle strobe
        preload(1'b1, 2'd2, 8'h0F);
        preload(1'b1, 2'd0, 8'hA0);
        run_op(1'b1, 3'd3, 2'd2, 2'd0, 8'h00, 1'b0);

        // Random ops on both instances
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                preload(1'(n % 2), 2'($urandom), 8'($urandom_range(0, 1) != 0 ? $urandom : 0));
            run_op(1'(n % 2), 3'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                   $urandom_range(0, 1) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
